// File: rtl/piano_pkg.sv
// Shared definitions for the note source arbiter.
//   NOTE_REST     : note code meaning "silence"
//   arb_state_e   : arbiter FSM states
//   SRC_*         : encodings driven on oSource
package piano_pkg;

  localparam logic [7:0] NOTE_REST = 8'h00;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_SONG = 2'd1;
  localparam logic [1:0] SRC_KEY  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SONG,
    S_KEY,
    S_GAP,
    S_HOLD
  } arb_state_e;

endpackage

// File: rtl/note_source_arbiter_if.sv
// Note bus between the producers (keyboard decoder, song player) and the
// arbiter, plus the arbiter's outputs toward the buzzer/display path.
//   iKey_Data / iSong_Data / iSong_Enable : producer side inputs
//   oFreq_Data / oCountEnable / oSongPause / oSource : arbiter results
// master = producer/consumer side, slave = arbiter side.
interface note_source_arbiter_if;
  logic [7:0] iKey_Data;
  logic [7:0] iSong_Data;
  logic       iSong_Enable;
  logic [7:0] oFreq_Data;
  logic       oCountEnable;
  logic       oSongPause;
  logic [1:0] oSource;

  modport master (
    output iKey_Data, iSong_Data, iSong_Enable,
    input  oFreq_Data, oCountEnable, oSongPause, oSource
  );

  modport slave (
    input  iKey_Data, iSong_Data, iSong_Enable,
    output oFreq_Data, oCountEnable, oSongPause, oSource
  );
endinterface

// File: rtl/arb_timer.sv
// Loadable saturating down-counter shared by the gap and hold phases.
//   iClk, iReset_n : clock, async active-high reset
//   i_load         : load i_value this cycle (wins over counting)
//   i_value        : value to load
//   o_done         : counter sits at zero
module arb_timer #(
  parameter int CNT_W = 24
) (
  input  logic             iClk,
  input  logic             iReset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge iClk or posedge iReset_n) begin
    if (iReset_n)            r_cnt <= '0;
    else if (i_load)         r_cnt <= i_value;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/note_source_arbiter.sv
// Picks the note sent to the buzzer: keyboard over song, a silent gap between
// two different sounding notes, a one-cycle start pulse per new note, and a
// pause window for the song after the last key release.
//   iClk, iReset_n : clock, async reset (active-high despite the name)
//   bus (slave)    : producer inputs and registered arbiter outputs
module note_source_arbiter
  import piano_pkg::*;
#(
  parameter int GAP_CYCLES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 24
) (
  input  logic                 iClk,
  input  logic                 iReset_n,
  note_source_arbiter_if.slave bus
);

  // Timer is loaded with N-1 and the phase ends on the edge where it reads
  // zero, giving exactly N cycles of silence / pause.
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);

  arb_state_e       r_state, w_state_nx;
  logic [7:0]       r_freq, w_freq_nx;
  logic [7:0]       r_target, w_target_nx;
  logic             r_owner_key, w_owner_key_nx;
  logic             r_cnt_en, w_cnt_en_nx;
  logic             r_pause, w_pause_nx;
  logic [1:0]       r_src, w_src_nx;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_done;

  logic [7:0] w_key, w_song;
  logic       w_en;
  assign w_key  = bus.iKey_Data;
  assign w_song = bus.iSong_Data;
  assign w_en   = bus.iSong_Enable;

  arb_timer #(.CNT_W(CNT_W)) u_timer (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .i_load   (w_load),
    .i_value  (w_load_val),
    .o_done   (w_done)
  );

  always_ff @(posedge iClk or posedge iReset_n) begin
    if (iReset_n) begin
      r_state     <= S_IDLE;
      r_freq      <= NOTE_REST;
      r_target    <= NOTE_REST;
      r_owner_key <= 1'b0;
      r_cnt_en    <= 1'b0;
      r_pause     <= 1'b0;
      r_src       <= SRC_NONE;
    end else begin
      r_state     <= w_state_nx;
      r_freq      <= w_freq_nx;
      r_target    <= w_target_nx;
      r_owner_key <= w_owner_key_nx;
      r_cnt_en    <= w_cnt_en_nx;
      r_pause     <= w_pause_nx;
      r_src       <= w_src_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_freq_nx      = r_freq;
    w_target_nx    = r_target;
    w_owner_key_nx = r_owner_key;
    w_cnt_en_nx    = 1'b0;
    w_load         = 1'b0;
    w_load_val     = GAP_LD;

    unique case (r_state)
      S_IDLE: begin
        w_freq_nx = NOTE_REST;
        if (w_key != NOTE_REST) begin
          w_state_nx = S_KEY; w_freq_nx = w_key; w_cnt_en_nx = 1'b1;
        end else if (w_en && w_song != NOTE_REST) begin
          w_state_nx = S_SONG; w_freq_nx = w_song; w_cnt_en_nx = 1'b1;
        end
      end

      S_SONG: begin
        if (w_key != NOTE_REST) begin
          // Preemption: only articulate if something is actually sounding.
          if (r_freq != NOTE_REST) begin
            w_state_nx = S_GAP; w_target_nx = w_key; w_owner_key_nx = 1'b1;
            w_freq_nx = NOTE_REST; w_load = 1'b1;
          end else begin
            w_state_nx = S_KEY; w_freq_nx = w_key; w_cnt_en_nx = 1'b1;
          end
        end else if (!w_en) begin
          w_state_nx = S_IDLE; w_freq_nx = NOTE_REST;
        end else if (w_song != r_freq) begin
          if (w_song == NOTE_REST) begin
            w_freq_nx = NOTE_REST;
          end else if (r_freq == NOTE_REST) begin
            w_freq_nx = w_song; w_cnt_en_nx = 1'b1;
          end else begin
            w_state_nx = S_GAP; w_target_nx = w_song; w_owner_key_nx = 1'b0;
            w_freq_nx = NOTE_REST; w_load = 1'b1;
          end
        end
      end

      S_KEY: begin
        if (w_key == NOTE_REST) begin
          w_state_nx = S_HOLD; w_freq_nx = NOTE_REST;
          w_load = 1'b1; w_load_val = HOLD_LD;
        end else if (w_key != r_freq) begin
          if (r_freq == NOTE_REST) begin
            w_freq_nx = w_key; w_cnt_en_nx = 1'b1;
          end else begin
            w_state_nx = S_GAP; w_target_nx = w_key; w_owner_key_nx = 1'b1;
            w_freq_nx = NOTE_REST; w_load = 1'b1;
          end
        end
      end

      S_GAP: begin
        // Gap length is fixed at entry; retargeting or an ownership steal by
        // the keyboard never reloads the timer.
        w_freq_nx = NOTE_REST;
        if (r_owner_key || w_key != NOTE_REST) begin
          if (w_key == NOTE_REST) begin
            w_state_nx = S_HOLD; w_load = 1'b1; w_load_val = HOLD_LD;
          end else begin
            w_owner_key_nx = 1'b1; w_target_nx = w_key;
            if (w_done) begin
              w_state_nx = S_KEY; w_freq_nx = w_key; w_cnt_en_nx = 1'b1;
            end
          end
        end else if (!w_en || w_song == NOTE_REST) begin
          w_state_nx = S_IDLE;
        end else begin
          w_target_nx = w_song;
          if (w_done) begin
            w_state_nx = S_SONG; w_freq_nx = w_song; w_cnt_en_nx = 1'b1;
          end
        end
      end

      S_HOLD: begin
        w_freq_nx = NOTE_REST;
        if (w_key != NOTE_REST) begin
          w_state_nx = S_KEY; w_freq_nx = w_key; w_cnt_en_nx = 1'b1;
        end else if (w_done) begin
          w_state_nx = S_IDLE;
        end
      end

      default: begin
        w_state_nx = S_IDLE; w_freq_nx = NOTE_REST;
      end
    endcase

    // Flags follow the state being entered so they line up with the note.
    unique case (w_state_nx)
      S_SONG:  w_src_nx = SRC_SONG;
      S_KEY:   w_src_nx = SRC_KEY;
      S_GAP:   w_src_nx = w_owner_key_nx ? SRC_KEY : SRC_SONG;
      default: w_src_nx = SRC_NONE;
    endcase
    w_pause_nx = (w_state_nx == S_KEY) || (w_state_nx == S_HOLD) ||
                 ((w_state_nx == S_GAP) && w_owner_key_nx);
  end

  assign bus.oFreq_Data   = r_freq;
  assign bus.oCountEnable = r_cnt_en;
  assign bus.oSongPause   = r_pause;
  assign bus.oSource      = r_src;

endmodule

// File: tb/tb_note_source_arbiter.sv
module tb_note_source_arbiter;

  localparam int GAP  = 4;
  localparam int HOLD = 16;

  logic iClk = 1'b0;
  logic iReset_n = 1'b1;
  always #5 iClk = ~iClk;

  note_source_arbiter_if bus();

  note_source_arbiter #(.GAP_CYCLES(GAP), .HOLD_CYCLES(HOLD), .CNT_W(24)) dut (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .bus      (bus)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model: who owns the buzzer, what is sounding, and how many
  // cycles of silence / song pause are still owed.
  logic [7:0] m_out;
  logic       m_pulse;
  int         m_owner;  // 0 none, 1 song, 2 key
  int         m_gap;    // remaining silent cycles of an articulation gap
  int         m_hold;   // remaining song-pause cycles after key release

  task automatic model_reset();
    m_out = 8'h00; m_pulse = 1'b0; m_owner = 0; m_gap = 0; m_hold = 0;
  endtask

  task automatic play(input logic [7:0] c);
    m_out = c; m_pulse = 1'b1;
  endtask

  // Follow the owner's input: silence or a new note after silence is
  // immediate, a change between two sounding notes needs a gap.
  task automatic follow(input logic [7:0] c);
    if (c == m_out) ;
    else if (c == 8'h00) m_out = 8'h00;
    else if (m_out == 8'h00) play(c);
    else begin m_out = 8'h00; m_gap = GAP; end
  endtask

  task automatic model_step(input logic [7:0] k, input logic [7:0] s, input logic en);
    m_pulse = 1'b0;
    if (m_gap > 0) begin
      m_gap--; m_out = 8'h00;
      if (m_owner == 2 || k != 0) begin
        m_owner = 2;
        if (k == 0) begin m_gap = 0; m_hold = HOLD; end
        else if (m_gap == 0) play(k);
      end else if (!en || s == 0) begin
        m_gap = 0; m_owner = 0;
      end else if (m_gap == 0) play(s);
    end else if (m_hold > 0) begin
      m_hold--; m_out = 8'h00;
      if (k != 0) begin m_hold = 0; play(k); end
      else if (m_hold == 0) m_owner = 0;
    end else if (m_owner == 0) begin
      m_out = 8'h00;
      if (k != 0) begin m_owner = 2; play(k); end
      else if (en && s != 0) begin m_owner = 1; play(s); end
    end else if (m_owner == 1) begin
      if (k != 0) begin
        m_owner = 2;
        if (m_out != 0) begin m_out = 8'h00; m_gap = GAP; end
        else play(k);
      end else if (!en) begin m_owner = 0; m_out = 8'h00; end
      else follow(s);
    end else begin
      if (k == 0) begin m_out = 8'h00; m_hold = HOLD; end
      else follow(k);
    end
  endtask

  function automatic logic [11:0] exp_vec();
    logic [1:0] src;
    src = (m_hold > 0) ? 2'd0 : 2'(m_owner);
    return {m_out, m_pulse, (m_owner == 2), src};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {bus.oFreq_Data, bus.oCountEnable, bus.oSongPause, bus.oSource};
  endfunction

  task automatic tick(input logic [7:0] k, input logic [7:0] s, input logic en);
    bus.iKey_Data = k; bus.iSong_Data = s; bus.iSong_Enable = en;
    @(posedge iClk);
    model_step(k, s, en);
    #1;
  endtask

  task automatic do_reset();
    bus.iKey_Data = 8'h00; bus.iSong_Data = 8'h00; bus.iSong_Enable = 1'b0;
    iReset_n = 1'b1;
    @(posedge iClk); #1;
    iReset_n = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if (dut_vec() !== 12'h000) begin
      errs++; $display("FAIL reset_state: dut=%h want=%h", dut_vec(), 12'h000);
    end
    tick(8'h00, 8'h15, 1'b1);
    tick(8'h00, 8'h15, 1'b1);
    vecs++;
    if (dut_vec() !== {8'h15, 1'b0, 1'b0, 2'd1}) begin
      errs++; $display("FAIL reset_prenote: dut=%h want=%h", dut_vec(), {8'h15, 1'b0, 1'b0, 2'd1});
    end
    #2 iReset_n = 1'b1;
    #1;
    vecs++;
    if (dut_vec() !== 12'h000) begin
      errs++; $display("FAIL reset_async: dut=%h want=%h", dut_vec(), 12'h000);
    end
    #1 iReset_n = 1'b0;
    model_reset();
    // back in idle: the held song note restarts with a fresh pulse
    tick(8'h00, 8'h15, 1'b1);
    vecs++;
    if (dut_vec() !== {8'h15, 1'b1, 1'b0, 2'd1}) begin
      errs++; $display("FAIL reset_restart: dut=%h want=%h", dut_vec(), {8'h15, 1'b1, 1'b0, 2'd1});
    end
  endtask

  task automatic test_song();
    logic [11:0] want;
    do_reset();
    tick(8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i < 2)      tick(8'h00, 8'h11, 1'b1);
      else            tick(8'h00, 8'h12, 1'b1);
      case (i)
        0:       want = {8'h11, 1'b1, 1'b0, 2'd1};
        1:       want = {8'h11, 1'b0, 1'b0, 2'd1};
        6:       want = {8'h12, 1'b1, 1'b0, 2'd1};
        7:       want = {8'h12, 1'b0, 1'b0, 2'd1};
        default: want = {8'h00, 1'b0, 1'b0, 2'd1};
      endcase
      vecs++;
      if (dut_vec() !== want || dut_vec() !== exp_vec()) begin
        errs++; $display("FAIL song[%0d]: dut=%h want=%h model=%h", i, dut_vec(), want, exp_vec());
      end
    end
  endtask

  task automatic test_preempt();
    logic [11:0] want;
    do_reset();
    tick(8'h00, 8'h11, 1'b1);
    tick(8'h00, 8'h11, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(8'h21, 8'h11, 1'b1);
      if (i < 4)      want = {8'h00, 1'b0, 1'b1, 2'd2};
      else if (i == 4) want = {8'h21, 1'b1, 1'b1, 2'd2};
      else            want = {8'h21, 1'b0, 1'b1, 2'd2};
      vecs++;
      if (dut_vec() !== want || dut_vec() !== exp_vec()) begin
        errs++; $display("FAIL preempt[%0d]: dut=%h want=%h model=%h", i, dut_vec(), want, exp_vec());
      end
    end
  endtask

  task automatic test_hold();
    logic [11:0] want;
    do_reset();
    tick(8'h21, 8'h11, 1'b1);
    // release, re-press on the 8th cycle of the hold window
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tick(8'h00, 8'h11, 1'b1);
      else       tick(8'h22, 8'h11, 1'b1);
      want = (i < 8) ? {8'h00, 1'b0, 1'b1, 2'd0} : {8'h22, 1'b1, 1'b1, 2'd2};
      vecs++;
      if (dut_vec() !== want || dut_vec() !== exp_vec()) begin
        errs++; $display("FAIL hold_repress[%0d]: dut=%h want=%h model=%h", i, dut_vec(), want, exp_vec());
      end
    end
    // release and let the window expire; song resumes one cycle later
    for (int i = 0; i < HOLD + 2; i++) begin
      tick(8'h00, 8'h11, 1'b1);
      if (i < HOLD)       want = {8'h00, 1'b0, 1'b1, 2'd0};
      else if (i == HOLD) want = {8'h00, 1'b0, 1'b0, 2'd0};
      else                want = {8'h11, 1'b1, 1'b0, 2'd1};
      vecs++;
      if (dut_vec() !== want || dut_vec() !== exp_vec()) begin
        errs++; $display("FAIL hold_expire[%0d]: dut=%h want=%h model=%h", i, dut_vec(), want, exp_vec());
      end
    end
  endtask

  task automatic test_retarget();
    logic [11:0] want;
    logic [7:0]  k;
    do_reset();
    tick(8'h21, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      k = (i < 2) ? 8'h23 : 8'h24;
      tick(k, 8'h00, 1'b0);
      if (i < 4)       want = {8'h00, 1'b0, 1'b1, 2'd2};
      else if (i == 4) want = {8'h24, 1'b1, 1'b1, 2'd2};
      else             want = {8'h24, 1'b0, 1'b1, 2'd2};
      vecs++;
      if (dut_vec() !== want || dut_vec() !== exp_vec()) begin
        errs++; $display("FAIL retarget[%0d]: dut=%h want=%h model=%h", i, dut_vec(), want, exp_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [11:0] want;
    do_reset();
    tick(8'h00, 8'h11, 1'b1);
    tick(8'h00, 8'h11, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(8'h30, 8'h13, 1'b1);
      if (i < 4)       want = {8'h00, 1'b0, 1'b1, 2'd2};
      else if (i == 4) want = {8'h30, 1'b1, 1'b1, 2'd2};
      else             want = {8'h30, 1'b0, 1'b1, 2'd2};
      vecs++;
      if (dut_vec() !== want || dut_vec() !== exp_vec()) begin
        errs++; $display("FAIL simultaneous[%0d]: dut=%h want=%h model=%h", i, dut_vec(), want, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] k, s;
    logic       en, prev_pulse;
    k = 8'h00; s = 8'h00; en = 1'b1; prev_pulse = 1'b0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0)
        k = ($urandom_range(0, 9) < 6) ? 8'h00 : 8'(8'h20 + $urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0)
        s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(8'h10 + $urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) en = ~en;
      tick(k, s, en);
      vecs++;
      if (dut_vec() !== exp_vec()) begin
        errs++; $display("FAIL random[%0d]: dut=%h model=%h", i, dut_vec(), exp_vec());
      end
      vecs++;
      if (bus.oCountEnable === 1'b1 && (bus.oFreq_Data === 8'h00 || prev_pulse)) begin
        errs++; $display("FAIL pulse_rule[%0d]: note=%h prev_pulse=%0b", i, bus.oFreq_Data, prev_pulse);
      end
      prev_pulse = bus.oCountEnable;
    end
  endtask

  initial begin
    bus.iKey_Data = 8'h00; bus.iSong_Data = 8'h00; bus.iSong_Enable = 1'b0;
    model_reset();
    test_reset();
    test_song();
    test_preempt();
    test_hold();
    test_retarget();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
